seq_ripple_adder: RTL and testbench



---
 rtl/seq_ripple_adder_pkg.sv | 13 +
 rtl/adder_segment.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/seq_ripple_adder.sv | 140 ++++++++++++++
 tb/tb_seq_ripple_adder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_ripple_adder_pkg.sv
// rtl/seq_ripple_adder_pkg.sv - shared types and constants for the sequential ripple adder
package seq_ripple_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_segment.sv
// rtl/adder_segment.sv - SEG-bit combinational ripple chain of full adder cells
module adder_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[SEG];
    // Carry entering the top bit; XOR with cout on the last segment gives signed overflow.
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_ripple_adder.sv
// rtl/seq_ripple_adder.sv - multi-cycle add/sub, SEG bits per clock with registered carry
module seq_ripple_adder
    import seq_ripple_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v
);

    localparam int NSEG = WIDTH / SEG;
    localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NSEG - 1);
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             c_q;
    logic             v_q;

    logic [31:0]      base;
    logic [SEG-1:0]   seg_a;
    logic [SEG-1:0]   seg_b;
    logic [SEG-1:0]   seg_s;
    logic             seg_cout;
    logic             seg_cmsb;
    logic             last;

    // Select the operand slice for the current segment index.
    always_comb begin
        base  = 32'(idx_q) * 32'(SEG);
        seg_a = SEG'(a_q >> base);
        seg_b = SEG'(b_q >> base);
        last  = (idx_q == LAST_IDX);
    end

    adder_segment #(
        .SEG (SEG)
    ) u_seg (
        .a     (seg_a),
        .b     (seg_b),
        .cin   (carry_q),
        .s     (seg_s),
        .cout  (seg_cout),
        .c_msb (seg_cmsb)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs; in_ready is held low during reset.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = reset_n;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, then one segment per RUN cycle into the result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= (in_sub == MODE_ADD) ? in_b : ~in_b;
                        carry_q <= (in_sub == MODE_SUB) ? ~in_c : in_c;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    s_q     <= (s_q & ~(SEG_MASK << base)) | (WIDTH'(seg_s) << base);
                    carry_q <= seg_cout;
                    if (last) begin
                        c_q <= seg_cout;
                        v_q <= seg_cmsb ^ seg_cout;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_s = s_q;
    assign out_c = c_q;
    assign out_v = v_q;

endmodule

// File: tb/tb_seq_ripple_adder.sv
// tb/tb_seq_ripple_adder.sv - scoreboard bench for seq_ripple_adder at SEG=4, 16 and 1
module tb_seq_ripple_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [2:0]       in_valid, in_ready, in_c, in_sub;
    logic [2:0]       out_valid, out_ready, out_c, out_v;
    logic [2:0][15:0] in_a, in_b, out_s;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int bad   = 0;

    seq_ripple_adder #(.WIDTH(16), .SEG(4)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
        .in_c(in_c[0]), .in_sub(in_sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_s(out_s[0]),
        .out_c(out_c[0]), .out_v(out_v[0])
    );

    seq_ripple_adder #(.WIDTH(16), .SEG(16)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
        .in_c(in_c[1]), .in_sub(in_sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_s(out_s[1]),
        .out_c(out_c[1]), .out_v(out_v[1])
    );

    seq_ripple_adder #(.WIDTH(16), .SEG(1)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_a(in_a[2]), .in_b(in_b[2]),
        .in_c(in_c[2]), .in_sub(in_sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_s(out_s[2]),
        .out_c(out_c[2]), .out_v(out_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int nseg(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic void push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    // Monitor: every transfer (out_valid && out_ready) pops and compares one expected result.
    always @(negedge clk) begin
        exp_t e;
        int   sz;
        for (int k = 0; k < 3; k++) begin
            if (reset_n && out_valid[k] && out_ready[k]) begin
                sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
                check($sformatf("expected_pending_%0d", k), 32'(sz > 0), 32'd1);
                if (sz > 0) begin
                    case (k)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    check($sformatf("out_s_%0d", k), 32'(out_s[k]), 32'(e.s));
                    check($sformatf("out_c_%0d", k), 32'(out_c[k]), 32'(e.c));
                    check($sformatf("out_v_%0d", k), 32'(out_v[k]), 32'(e.v));
                end
            end
        end
    end

    task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sub,
                         input logic [15:0] es, input logic ec, input logic ev, input bit bp);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_op", 32'(in_ready[k]), 32'd1);
        push(k, '{s: es, c: ec, v: ev});
        out_ready[k] = !bp;
        in_a[k] = a; in_b[k] = b; in_c[k] = c; in_sub[k] = sub;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_a[k] = 16'hDEAD; in_b[k] = 16'hBEEF; in_c[k] = ~c; in_sub[k] = ~sub;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid[k] && n < 40);
        check($sformatf("latency_%0d", k), 32'(n), 32'(nseg(k)));
        if (bp) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("bp_valid", 32'(out_valid[k]), 32'd1);
                check("bp_s", 32'(out_s[k]), 32'(es));
                check("bp_cv", 32'({out_c[k], out_v[k]}), 32'({ec, ev}));
                check("bp_in_ready", 32'(in_ready[k]), 32'd0);
                in_valid[k] = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            @(posedge clk);
            #1;
            check("bp_release_ready", 32'(in_ready[k]), 32'd1);
            check("bp_release_valid", 32'(out_valid[k]), 32'd0);
        end else begin
            @(posedge clk);
            #1;
            check($sformatf("back_to_idle_%0d", k), 32'({out_valid[k], in_ready[k]}), 32'b01);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        v;
    } vec_t;

    vec_t plan[5];
    vec_t sweep[5];

    initial begin
        plan[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        plan[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        plan[2]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        plan[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        plan[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        sweep[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h68AC, 1'b0, 1'b0};
        sweep[1] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        sweep[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        sweep[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        sweep[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        reset_n   = 1'b0;
        in_valid  = '0; in_c = '0; in_sub = '0;
        in_a      = '0; in_b = '0;
        out_ready = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_outputs_%0d", k),
                  32'({out_valid[k], in_ready[k], out_c[k], out_v[k], out_s[k]}), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(in_ready), 32'b111);

        foreach (plan[i])
            do_op(0, plan[i].a, plan[i].b, plan[i].c, plan[i].sub,
                  plan[i].s, plan[i].co, plan[i].v, 1'b0);

        do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("no_queued_op", 32'(out_valid[0]), 32'd0);

        @(negedge clk);
        in_a[0] = 16'hAAAA; in_b[0] = 16'h5555; in_c[0] = 1'b0; in_sub[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_reset_outputs",
              32'({out_valid[0], in_ready[0], out_c[0], out_v[0], out_s[0]}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        for (int k = 1; k < 3; k++) begin
            foreach (sweep[i])
                do_op(k, sweep[i].a, sweep[i].b, sweep[i].c, sweep[i].sub,
                      sweep[i].s, sweep[i].co, sweep[i].v, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
